cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: cycles for in-flight EX/MEM/WB instructions to retire after fetch stops.
REQ-002 SHALL have parameter RST_CYCLES, default 4: width of the CPU reset pulse.
REQ-003 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-004 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid_i  in  1  host command valid.
REQ-007 cmd_op_i  in  2  command: 00 RUN, 01 STEP, 10 STOP, 11 CPU_RESET.
REQ-008 cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both high on a clock edge.
REQ-009 halt_seen_i  in  1  freeze level from the halt unit (HALT instruction in ID).
REQ-010 retire_i  in  1  one instruction retired in WB this cycle.
REQ-011 fetch_en_o  out  1  PC/IF-ID advance enable; back-end stages are not gated.
REQ-012 cpu_rst_o  out  1  synchronous reset to the core datapath.
REQ-013 halted_o  out  1  core stopped and pipeline drained.
REQ-014 step_done_o  out  1  one-cycle pulse when a STEP completes.
REQ-015 cycle_count_o  out  CNT_W  count of cycles with fetch_en_o high.
REQ-016 retired_count_o  out  CNT_W  count of retired instructions.

Function
REQ-017 SHALL implement FSM states HALTED, RUNNING, STEP, DRAIN, CPU_RST, all outputs registered.
REQ-018 cmd_ready_o SHALL be 1 in HALTED and RUNNING, and 0 in STEP, DRAIN and CPU_RST.
REQ-019 HALTED: RUN -> RUNNING; STEP -> STEP; CPU_RESET -> CPU_RST; STOP SHALL be accepted with no effect.
REQ-020 RUNNING: STOP, or a rising edge of halt_seen_i (registered edge detect), -> DRAIN; CPU_RESET -> CPU_RST; RUN/STEP SHALL be accepted and ignored.
REQ-021 Simultaneous STOP and halt_seen_i rising edge SHALL produce a single DRAIN entry. CPU_RESET SHALL take priority over the halt edge.
REQ-022 fetch_en_o SHALL be 1 exactly in RUNNING and STEP; STEP SHALL last exactly one cycle, then -> DRAIN, regardless of halt_seen_i.
REQ-023 halt_seen_i held high (no new rising edge) after RUN SHALL NOT re-enter DRAIN.
REQ-024 DRAIN SHALL last exactly DRAIN_CYCLES cycles (internal down-counter), then -> HALTED.
REQ-025 step_done_o SHALL pulse for one cycle in the first HALTED cycle only if DRAIN was entered from STEP.
REQ-026 CPU_RST SHALL hold cpu_rst_o=1 for exactly RST_CYCLES cycles and clear both counters, then -> HALTED.
REQ-027 halted_o SHALL equal (state == HALTED).
REQ-028 cycle_count_o SHALL increment by 1 every cycle fetch_en_o=1, wrapping modulo 2^CNT_W.
REQ-029 retired_count_o SHALL increment on retire_i in every state except CPU_RST, wrapping modulo 2^CNT_W.

Reset
REQ-030 On rst_i=1, regardless of current state, SHALL enter HALTED with fetch_en_o=0, cpu_rst_o=0, halted_o=1, step_done_o=0, cmd_ready_o=1, counters=0, and the edge-detect register=0.
REQ-031 An in-progress DRAIN, STEP or CPU_RST SHALL be abandoned immediately on rst_i.

Structure
REQ-032 Package run_ctrl_pkg SHALL hold the state enum, the cmd_op enum, and the default DRAIN_CYCLES/RST_CYCLES/CNT_W values.
REQ-033 Sub-module event_counter (CNT_W-wide, enable, synchronous clear, wrap) SHALL be instantiated twice, for the cycle and retired counters.

Verification
REQ-034 Reset, then RUN for 10 cycles with retire_i=1 each cycle, then STOP -> fetch_en_o high 10 cycles; halted_o=1 exactly 3 cycles after DRAIN entry; cycle_count_o=10; retired_count_o>=10.
REQ-035 RUN, then halt_seen_i rises and stays high for 20 cycles -> DRAIN entered once, HALTED after 3 cycles, no re-entry.
REQ-036 STEP from HALTED -> fetch_en_o high exactly 1 cycle, cmd_ready_o=0 for 4 cycles, step_done_o pulses once, cycle_count_o increments by 1.
REQ-037 STOP and halt_seen_i rising edge in the same cycle -> single DRAIN of 3 cycles; CPU_RESET with a halt edge in the same cycle -> CPU_RST.
REQ-038 CPU_RESET with counters at 0xFFFFFFFF -> cpu_rst_o high 4 cycles, counters=0, halted_o=1; separately, counter wrap 0xFFFFFFFF -> 0 on the next increment.
REQ-039 Assert rst_i asynchronously mid-DRAIN -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the CPU run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALTED,
    ST_RUNNING,
    ST_STEP,
    ST_DRAIN,
    ST_CPU_RST
  } run_state_e;

  typedef enum logic [1:0] {
    OP_RUN       = 2'b00,
    OP_STEP      = 2'b01,
    OP_STOP      = 2'b10,
    OP_CPU_RESET = 2'b11
  } cmd_op_e;

  localparam int unsigned DEF_DRAIN_CYCLES = 3;
  localparam int unsigned DEF_RST_CYCLES   = 4;
  localparam int unsigned DEF_CNT_W        = 32;

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with enable and synchronous clear.
module event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      count_o <= '0;
    else if (clr_i) count_o <= '0;
    else if (en_i)  count_o <= count_o + CNT_W'(1);
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-facing run/step/stop/reset controller for the CPU pipeline, with
// fetch-cycle and retired-instruction performance counters.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_op_i,
  output logic             cmd_ready_o,
  input  logic             halt_seen_i,
  input  logic             retire_i,
  output logic             fetch_en_o,
  output logic             cpu_rst_o,
  output logic             halted_o,
  output logic             step_done_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] retired_count_o
);

  localparam int unsigned TMR_MAX = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             from_step_q, from_step_d;
  logic             halt_q;
  logic             step_done_d;
  logic             cmd_acc, halt_rise;
  cmd_op_e          op;

  assign op        = cmd_op_e'(cmd_op_i);
  assign cmd_acc   = cmd_valid_i & cmd_ready_o;
  assign halt_rise = halt_seen_i & ~halt_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    from_step_d = from_step_q;
    step_done_d = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (cmd_acc) begin
          case (op)
            OP_RUN:       state_d = ST_RUNNING;
            OP_STEP:      state_d = ST_STEP;
            OP_CPU_RESET: begin
              state_d = ST_CPU_RST;
              tmr_d   = RST_LOAD;
            end
            default:      ;
          endcase
        end
      end
      ST_RUNNING: begin
        // CPU_RESET outranks both STOP and a coincident halt edge.
        if (cmd_acc && op == OP_CPU_RESET) begin
          state_d = ST_CPU_RST;
          tmr_d   = RST_LOAD;
        end else if ((cmd_acc && op == OP_STOP) || halt_rise) begin
          state_d     = ST_DRAIN;
          tmr_d       = DRAIN_LOAD;
          from_step_d = 1'b0;
        end
      end
      ST_STEP: begin
        state_d     = ST_DRAIN;
        tmr_d       = DRAIN_LOAD;
        from_step_d = 1'b1;
      end
      ST_DRAIN: begin
        if (tmr_q == '0) begin
          state_d     = ST_HALTED;
          step_done_d = from_step_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_CPU_RST: begin
        if (tmr_q == '0) state_d = ST_HALTED;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HALTED;
      tmr_q       <= '0;
      from_step_q <= 1'b0;
      halt_q      <= 1'b0;
      fetch_en_o  <= 1'b0;
      cpu_rst_o   <= 1'b0;
      halted_o    <= 1'b1;
      step_done_o <= 1'b0;
      cmd_ready_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      from_step_q <= from_step_d;
      halt_q      <= halt_seen_i;
      fetch_en_o  <= (state_d == ST_RUNNING) || (state_d == ST_STEP);
      cpu_rst_o   <= (state_d == ST_CPU_RST);
      halted_o    <= (state_d == ST_HALTED);
      step_done_o <= step_done_d;
      cmd_ready_o <= (state_d == ST_HALTED) || (state_d == ST_RUNNING);
    end
  end

  event_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (fetch_en_o),
    .clr_i   (cpu_rst_o),
    .count_o (cycle_count_o)
  );

  event_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (retire_i & ~cpu_rst_o),
    .clr_i   (cpu_rst_o),
    .count_o (retired_count_o)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a default-width instance plus a 4-bit
// counter instance on the same stimulus so counter wrap is reachable.
module tb_cpu_run_ctrl;

  localparam int unsigned SW = 4;
  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_STOP = 2'b10, C_CRST = 2'b11;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_CRST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       halt_seen = 1'b0;
  logic       retire = 1'b0;

  logic a_ready, a_fetch, a_crst, a_halted, a_done;
  logic [31:0] a_cyc, a_ret;
  logic b_ready, b_fetch, b_crst, b_halted, b_done;
  logic [SW-1:0] b_cyc, b_ret;

  int tests = 0;
  int fails = 0;

  cpu_run_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op),
    .cmd_ready_o(a_ready), .halt_seen_i(halt_seen), .retire_i(retire),
    .fetch_en_o(a_fetch), .cpu_rst_o(a_crst), .halted_o(a_halted),
    .step_done_o(a_done), .cycle_count_o(a_cyc), .retired_count_o(a_ret)
  );

  cpu_run_ctrl #(.CNT_W(SW)) dut_w (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op),
    .cmd_ready_o(b_ready), .halt_seen_i(halt_seen), .retire_i(retire),
    .fetch_en_o(b_fetch), .cpu_rst_o(b_crst), .halted_o(b_halted),
    .step_done_o(b_done), .cycle_count_o(b_cyc), .retired_count_o(b_ret)
  );

  always #5 clk = ~clk;

  // Behavioural model: current mode, cycles left in it, unbounded counts.
  int              m_mode = M_HALT;
  int              m_left = 0;
  bit              m_from_step = 1'b0;
  bit              m_done = 1'b0;
  bit              m_hprev = 1'b0;
  longint unsigned m_cyc = 0;
  longint unsigned m_ret = 0;

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    bit rise;
    if (rst) begin
      m_mode = M_HALT; m_left = 0; m_from_step = 0; m_done = 0; m_hprev = 0;
      m_cyc = 0; m_ret = 0;
    end else begin
      acc  = cmd_valid && (m_mode == M_HALT || m_mode == M_RUN);
      rise = halt_seen && !m_hprev;
      if (m_mode == M_RUN || m_mode == M_STEP) m_cyc++;
      if (m_mode == M_CRST) begin m_cyc = 0; m_ret = 0; end
      else if (retire) m_ret++;
      m_done = 0;
      case (m_mode)
        M_HALT: if (acc) begin
          if (cmd_op == C_RUN) m_mode = M_RUN;
          else if (cmd_op == C_STEP) m_mode = M_STEP;
          else if (cmd_op == C_CRST) begin m_mode = M_CRST; m_left = 4; end
        end
        M_RUN: begin
          if (acc && cmd_op == C_CRST) begin m_mode = M_CRST; m_left = 4; end
          else if ((acc && cmd_op == C_STOP) || rise) begin
            m_mode = M_DRAIN; m_left = 3; m_from_step = 0;
          end
        end
        M_STEP: begin m_mode = M_DRAIN; m_left = 3; m_from_step = 1; end
        M_DRAIN: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_HALT; m_done = m_from_step; end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = M_HALT;
        end
      endcase
      m_hprev = halt_seen;
    end
  end

  int mon_fetch = 0, mon_nrdy = 0, mon_done = 0, mon_drain = 0, mon_crst = 0;

  always @(negedge clk) begin : compare
    logic [4:0] exp_ctl, got_a, got_b;
    exp_ctl = {(m_mode == M_RUN || m_mode == M_STEP), (m_mode == M_HALT || m_mode == M_RUN),
               (m_mode == M_CRST), (m_mode == M_HALT), m_done};
    got_a = {a_fetch, a_ready, a_crst, a_halted, a_done};
    got_b = {b_fetch, b_ready, b_crst, b_halted, b_done};
    tests++;
    if (got_a !== exp_ctl || got_b !== exp_ctl || a_cyc !== m_cyc[31:0] ||
        a_ret !== m_ret[31:0] || b_cyc !== m_cyc[SW-1:0] || b_ret !== m_ret[SW-1:0]) begin
      fails++;
      $display("FAIL per_cycle t=%0t ctl{fetch,ready,rst,halted,done} a=%b b=%b exp=%b cyc a=%0d b=%0d exp=%0d ret a=%0d b=%0d exp=%0d",
               $time, got_a, got_b, exp_ctl, a_cyc, b_cyc, m_cyc, a_ret, b_ret, m_ret);
    end
    if (a_fetch) mon_fetch++;
    if (!a_ready) mon_nrdy++;
    if (a_done) mon_done++;
    if (a_crst) mon_crst++;
    if (!a_fetch && !a_ready && !a_crst && !a_halted) mon_drain++;
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic clr_mon();
    mon_fetch = 0; mon_nrdy = 0; mon_done = 0; mon_drain = 0; mon_crst = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_halted", a_halted, 1);
    chk("rst_ready", a_ready, 1);
    chk("rst_fetch", a_fetch, 0);
    chk("rst_cycles", a_cyc, 0);
    rst = 1'b0;
    tick();

    // RUN 10 cycles with retire, then STOP
    clr_mon();
    send(C_RUN);
    retire = 1'b1;
    repeat (9) tick();
    send(C_STOP);
    retire = 1'b0;
    chk("drain_c1_halted", a_halted, 0);
    tick(); tick();
    chk("drain_c3_halted", a_halted, 0);
    tick();
    chk("drain_done_halted", a_halted, 1);
    chk("run10_fetch_cycles", mon_fetch, 10);
    chk("run10_cycle_count", a_cyc, 10);
    chk("run10_retired", a_ret, 10);
    chk("run10_small_cycle", b_cyc, 10);

    // single STEP
    clr_mon();
    send(C_STEP);
    repeat (6) tick();
    chk("step_fetch_cycles", mon_fetch, 1);
    chk("step_notready_cycles", mon_nrdy, 4);
    chk("step_done_pulses", mon_done, 1);
    chk("step_cycle_count", a_cyc, 11);

    // halt_seen rises during RUN and stays high
    send(C_RUN);
    tick(); tick();
    halt_seen = 1'b1;
    clr_mon();
    repeat (20) tick();
    chk("halt_drain_cycles", mon_drain, 3);
    chk("halt_halted", a_halted, 1);
    chk("halt_cycle_count", a_cyc, 14);
    clr_mon();
    send(C_RUN);
    repeat (5) tick();
    chk("halt_held_running", a_fetch, 1);
    chk("halt_held_no_drain", mon_drain, 0);

    // STOP coincident with a halt edge
    halt_seen = 1'b0;
    tick();
    halt_seen = 1'b1;
    clr_mon();
    send(C_STOP);
    repeat (6) tick();
    chk("stop_edge_drain_cycles", mon_drain, 3);
    chk("stop_edge_halted", a_halted, 1);
    halt_seen = 1'b0;

    // CPU_RESET coincident with a halt edge
    send(C_RUN);
    tick();
    halt_seen = 1'b1;
    clr_mon();
    send(C_CRST);
    repeat (6) tick();
    chk("crst_edge_rst_cycles", mon_crst, 4);
    chk("crst_edge_no_drain", mon_drain, 0);
    chk("crst_cycle_cleared", a_cyc, 0);
    chk("crst_retired_cleared", a_ret, 0);
    chk("crst_halted", a_halted, 1);
    halt_seen = 1'b0;

    // bring 4-bit counters to all-ones, then CPU_RESET
    send(C_RUN);
    retire = 1'b1;
    repeat (14) tick();
    send(C_STOP);
    retire = 1'b0;
    chk("max_small_cycle", b_cyc, 15);
    chk("max_small_retired", b_ret, 15);
    chk("max_big_cycle", a_cyc, 15);
    repeat (3) tick();
    clr_mon();
    send(C_CRST);
    repeat (4) tick();
    chk("max_crst_cycles", mon_crst, 4);
    chk("max_crst_small_cycle", b_cyc, 0);
    chk("max_crst_small_retired", b_ret, 0);
    chk("max_crst_halted", a_halted, 1);

    // wrap all-ones -> 0 on the next increment
    send(C_RUN);
    repeat (14) tick();
    chk("wrap_pre14", b_cyc, 14);
    tick();
    chk("wrap_at_max", b_cyc, 15);
    send(C_STOP);
    chk("wrap_to_zero", b_cyc, 0);
    chk("wrap_big_16", a_cyc, 16);
    repeat (3) tick();

    // asynchronous reset mid-DRAIN
    send(C_RUN);
    tick(); tick();
    send(C_STOP);
    tick();
    chk("mid_drain_not_halted", a_halted, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_halted", a_halted, 1);
    chk("async_fetch", a_fetch, 0);
    chk("async_ready", a_ready, 1);
    chk("async_cpu_rst", a_crst, 0);
    chk("async_step_done", a_done, 0);
    chk("async_cycle", a_cyc, 0);
    chk("async_small_cycle", b_cyc, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
